// File: rtl/ob_pkg.sv
// Shared order-book types: command encoding, UID type and the matured-to-executable
// rewrite applied to conditional (stop) commands when they leave the stop table.
package ob_pkg;

  localparam int UID_W   = 8;
  localparam int PRICE_W = 16;
  localparam int QTY_W   = 16;

  typedef enum logic [2:0] {
    OP_NOP         = 3'd0,
    OP_LIMIT_BUY   = 3'd1,
    OP_LIMIT_SELL  = 3'd2,
    OP_MARKET_BUY  = 3'd3,
    OP_MARKET_SELL = 3'd4,
    OP_STOP_BUY    = 3'd5,
    OP_STOP_SELL   = 3'd6,
    OP_CANCEL      = 3'd7
  } op_e;

  typedef logic [UID_W-1:0] uid_t;

  typedef struct packed {
    op_e                op;
    uid_t               uid;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // A matured stop becomes a market order on the same side; every other field is kept.
  function automatic cmd_t mtr_to_exec(input cmd_t c);
    cmd_t r;
    r = c;
    case (c.op)
      OP_STOP_BUY:  r.op = OP_MARKET_BUY;
      OP_STOP_SELL: r.op = OP_MARKET_SELL;
      default:      r.op = c.op;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ob_mtr_inject_q.sv
// Two-entry compacting FIFO. Entry 0 is always the head; holes left by a pop or a
// cancel are squeezed out on the next edge, and a push lands behind the survivors.
// Cancel compares against stored entries only, never against the entry being pushed.
// A cancel that matches the head while it is being popped is ignored: the pop wins.
module ob_mtr_inject_q
  import ob_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  cmd_t       push_cmd,
  input  logic       pop,
  input  logic       cancel,
  input  uid_t       cancel_uid,
  output logic       head_vld,
  output cmd_t       head,
  output logic [1:0] occupancy,
  output logic       cancel_hit
);

  logic [1:0] vld_q;
  cmd_t       data_q [2];

  logic [1:0] nxt_vld;
  cmd_t       nxt_data [2];
  logic       pop_eff;
  logic       hit0;
  logic       hit1;
  logic       keep0;
  logic       keep1;
  logic       fill1;

  assign head_vld  = vld_q[0];
  assign head      = data_q[0];
  assign occupancy = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};

  // Per-entry UID match, removal decisions and compacted next contents.
  always_comb begin
    pop_eff    = pop && vld_q[0];
    hit0       = cancel && vld_q[0] && (data_q[0].uid == cancel_uid) && !pop_eff;
    hit1       = cancel && vld_q[1] && (data_q[1].uid == cancel_uid);
    cancel_hit = hit0 || hit1;
    keep0      = vld_q[0] && !pop_eff && !hit0;
    keep1      = vld_q[1] && !hit1;

    nxt_vld     = 2'b00;
    nxt_data[0] = data_q[0];
    nxt_data[1] = data_q[1];
    fill1       = 1'b0;

    if (keep0) begin
      nxt_vld[0]  = 1'b1;
      nxt_data[0] = data_q[0];
      fill1       = 1'b1;
    end
    if (keep1) begin
      if (!fill1) begin
        nxt_vld[0]  = 1'b1;
        nxt_data[0] = data_q[1];
        fill1       = 1'b1;
      end else begin
        nxt_vld[1]  = 1'b1;
        nxt_data[1] = data_q[1];
      end
    end
    // The caller only pushes when a slot is (or is becoming) free.
    if (push) begin
      if (!nxt_vld[0]) begin
        nxt_vld[0]  = 1'b1;
        nxt_data[0] = push_cmd;
      end else begin
        nxt_vld[1]  = 1'b1;
        nxt_data[1] = push_cmd;
      end
    end
  end

  // Queue storage update; reset empties the queue and zeroes the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 2'b00;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      vld_q     <= nxt_vld;
      data_q[0] <= nxt_data[0];
      data_q[1] <= nxt_data[1];
    end
  end

endmodule

// File: rtl/ob_mtr_inject.sv
// Merges matured conditional commands with the ingress command stream into one
// stream for the order-book controller. Matured commands win arbitration unless
// ingress has already waited through STARVE_N consecutive matured wins.
// Optional statistics counters are built when OB_MTR_INJECT_STATS_EN is defined.
//
// Handshake: a source transfers a command in any cycle where its valid and its
// accept are both high. Accepts are combinational, mutually exclusive, never high
// without the matching valid and always low while rst is high. The output side
// transfers when out_vld_r && out_accept; out_r is stable until that happens
// (unless the head is cancelled).
module ob_mtr_inject
  import ob_pkg::*;
#(
  parameter int STARVE_N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  cmd_t        in_cmd_r,
  output logic        in_accept,
  input  logic        mtr_vld_r,
  input  cmd_t        mtr_r,
  output logic        mtr_accept,
  input  logic        cancel,
  input  uid_t        cancel_uid,
  output logic        cancel_hit_w,
  output logic        out_vld_r,
  output cmd_t        out_r,
  input  logic        out_accept
`ifdef OB_MTR_INJECT_STATS_EN
  ,
  output logic [31:0] stat_mtr_cnt_r,
  output logic [15:0] stat_starve_cnt_r
`endif
);

  localparam int STARVE_W = (STARVE_N < 1) ? 1 : $clog2(STARVE_N + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_N);

  logic [STARVE_W-1:0] starve_q;
  logic [1:0]          occupancy;
  logic                pop;
  logic                space;
  logic                in_forced;
  logic                grant_mtr;
  logic                grant_in;
  logic                push;
  cmd_t                push_cmd;
  logic                q_hit;

  // Arbitration: matured first, ingress when idle matured or when ingress is starved.
  always_comb begin
    pop       = out_vld_r && out_accept;
    space     = (occupancy < 2'd2) || pop;
    in_forced = in_vld && (starve_q == STARVE_MAX);
    grant_mtr = !rst && space && mtr_vld_r && !in_forced;
    grant_in  = !rst && space && in_vld && !grant_mtr;
    push      = grant_mtr || grant_in;
    push_cmd  = grant_mtr ? mtr_to_exec(mtr_r) : in_cmd_r;
  end

  assign mtr_accept   = grant_mtr;
  assign in_accept    = grant_in;
  assign cancel_hit_w = q_hit && !rst;

  // Starve counter: counts matured wins while ingress waits, frozen while there is no space.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (space) begin
      if (!in_vld || grant_in) begin
        starve_q <= '0;
      end else if (grant_mtr && (starve_q != STARVE_MAX)) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  ob_mtr_inject_q u_q (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_cmd   (push_cmd),
    .pop        (pop),
    .cancel     (cancel),
    .cancel_uid (cancel_uid),
    .head_vld   (out_vld_r),
    .head       (out_r),
    .occupancy  (occupancy),
    .cancel_hit (q_hit)
  );

`ifdef OB_MTR_INJECT_STATS_EN
  logic forced_grant;
  assign forced_grant = grant_in && mtr_vld_r && in_forced;

  // Wrapping statistics: matured pushes and ingress grants forced by the starve guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_mtr_cnt_r    <= '0;
      stat_starve_cnt_r <= '0;
    end else begin
      if (grant_mtr) begin
        stat_mtr_cnt_r <= stat_mtr_cnt_r + 32'd1;
      end
      if (forced_grant) begin
        stat_starve_cnt_r <= stat_starve_cnt_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ob_mtr_inject.sv
// Bench for ob_mtr_inject: directed scenarios plus randomized traffic, checked
// against a queue-level reference model and a decoupled output monitor.
module tb_ob_mtr_inject;
  import ob_pkg::*;

  localparam int STARVE_N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_vld;
  cmd_t in_cmd_r;
  logic in_accept;
  logic mtr_vld_r;
  cmd_t mtr_r;
  logic mtr_accept;
  logic cancel;
  uid_t cancel_uid;
  logic cancel_hit_w;
  logic out_vld_r;
  cmd_t out_r;
  logic out_accept;
`ifdef OB_MTR_INJECT_STATS_EN
  logic [31:0] stat_mtr_cnt_r;
  logic [15:0] stat_starve_cnt_r;
  int unsigned stat_m_exp;
  int unsigned stat_s_exp;
`endif

  ob_mtr_inject #(.STARVE_N(STARVE_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_cmd_r     (in_cmd_r),
    .in_accept    (in_accept),
    .mtr_vld_r    (mtr_vld_r),
    .mtr_r        (mtr_r),
    .mtr_accept   (mtr_accept),
    .cancel       (cancel),
    .cancel_uid   (cancel_uid),
    .cancel_hit_w (cancel_hit_w),
    .out_vld_r    (out_vld_r),
    .out_r        (out_r),
    .out_accept   (out_accept)
`ifdef OB_MTR_INJECT_STATS_EN
    ,
    .stat_mtr_cnt_r    (stat_mtr_cnt_r),
    .stat_starve_cnt_r (stat_starve_cnt_r)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [CMD_W-1:0] exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   starve_m = 0;
  bit   mon_en = 0;
  bit   last_ia;
  bit   last_ma;
  logic [7:0] next_uid = 8'd100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference rewrite: stop orders become market orders on the same side.
  function automatic cmd_t ref_exec(input cmd_t c);
    cmd_t r;
    r = c;
    if (c.op == OP_STOP_BUY)  r.op = OP_MARKET_BUY;
    if (c.op == OP_STOP_SELL) r.op = OP_MARKET_SELL;
    return r;
  endfunction

  function automatic cmd_t mk(input op_e op, input uid_t uid);
    cmd_t c;
    c.op    = op;
    c.uid   = uid;
    c.price = 16'($urandom_range(0, 65535));
    c.qty   = 16'($urandom_range(1, 1000));
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input bit matured);
    cmd_t c;
    op_e  op;
    if (matured && ($urandom_range(0, 3) != 0))
      op = ($urandom_range(0, 1) == 0) ? OP_STOP_BUY : OP_STOP_SELL;
    else
      op = op_e'($urandom_range(0, 7));
    c = mk(op, next_uid);
    next_uid = next_uid + 8'd1;
    return c;
  endfunction

  // ---------------- monitor ----------------
  // Compares the head against the oldest expected command and retires it on transfer.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("out_vld_r", out_vld_r, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_r", out_r, exp_q[0]);
        if (out_accept) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle, predicts accepts / cancel hit from the model, then updates the model.
  task automatic do_cycle(input bit iv, input cmd_t ic, input bit mv, input cmd_t mc,
                          input bit cv, input uid_t cu, input bit oa);
    int   sz;
    int   ci;
    bit   pop_m;
    bit   space_m;
    bit   forced_m;
    bit   e_m;
    bit   e_i;
    cmd_t tmp;
    @(posedge clk); #1;
    in_vld = iv; in_cmd_r = ic; mtr_vld_r = mv; mtr_r = mc;
    cancel = cv; cancel_uid = cu; out_accept = oa;
    sz       = exp_q.size();
    pop_m    = oa && (sz > 0);
    space_m  = (sz < 2) || pop_m;
    forced_m = iv && (starve_m == STARVE_N);
    e_m      = space_m && mv && !forced_m;
    e_i      = space_m && iv && !e_m;
    ci = -1;
    if (cv) begin
      for (int j = 0; j < sz; j++) begin
        tmp = exp_q[j];
        if (!(pop_m && j == 0) && tmp.uid == cu) ci = j;
      end
    end
    @(negedge clk); #1;
    check("in_accept", in_accept, e_i);
    check("mtr_accept", mtr_accept, e_m);
    check("cancel_hit_w", cancel_hit_w, ci >= 0);
    last_ia = in_accept;
    last_ma = mtr_accept;
    // The monitor has already retired the head if it was popped.
    if (ci >= 0) exp_q.delete(pop_m ? ci - 1 : ci);
    if (e_m) exp_q.push_back(ref_exec(mc));
    else if (e_i) exp_q.push_back(ic);
    if (space_m) begin
      if (!iv || e_i) starve_m = 0;
      else if (e_m && starve_m < STARVE_N) starve_m++;
    end
`ifdef OB_MTR_INJECT_STATS_EN
    if (e_m) stat_m_exp++;
    if (e_i && mv && forced_m) stat_s_exp++;
`endif
  endtask

  task automatic idle(input bit oa);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, oa);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_vld = 1'b1; mtr_vld_r = 1'b1; cancel = 1'b1; out_accept = 1'b1;
    cancel_uid = out_r.uid;
    @(negedge clk);
    check("rst in_accept", in_accept, 1'b0);
    check("rst mtr_accept", mtr_accept, 1'b0);
    check("rst cancel_hit_w", cancel_hit_w, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; in_vld = 1'b0; mtr_vld_r = 1'b0; cancel = 1'b0; out_accept = 1'b0;
    exp_q.delete();
    starve_m = 0;
    check("rst out_vld_r", out_vld_r, 1'b0);
    check("rst out_r", out_r, '0);
`ifdef OB_MTR_INJECT_STATS_EN
    stat_m_exp = 0;
    stat_s_exp = 0;
    check("rst stat_mtr", stat_mtr_cnt_r, 0);
    check("rst stat_starve", stat_starve_cnt_r, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  bit   exp_mtr_win [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit   pi;
  bit   pm;
  cmd_t pic;
  cmd_t pmc;
  uid_t cu;
  cmd_t tmp_c;

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_cmd_r = '0; mtr_vld_r = 1'b0; mtr_r = '0;
    cancel = 1'b0; cancel_uid = '0; out_accept = 1'b0;
`ifdef OB_MTR_INJECT_STATS_EN
    stat_m_exp = 0;
    stat_s_exp = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset out_vld_r", out_vld_r, 1'b0);
    check("reset out_r", out_r, '0);
    mon_en = 1'b1;

    // Single matured stop-buy into an empty queue.
    do_cycle(1'b0, '0, 1'b1, mk(OP_STOP_BUY, 8'd5), 1'b0, '0, 1'b0);
    check("single mtr_accept", last_ma, 1'b1);
    idle(1'b1);

    // Starve guard with both sources always valid.
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, rand_cmd(1'b0), 1'b1, rand_cmd(1'b1), 1'b0, '0, 1'b1);
      check("starve grant", {last_ma, last_ia}, exp_mtr_win[i] ? 2'b10 : 2'b01);
    end
    idle(1'b1); idle(1'b1);

    // Full queue, then pop with same-cycle push.
    do_cycle(1'b1, mk(OP_LIMIT_BUY, 8'd1), 1'b0, '0, 1'b0, '0, 1'b0);
    do_cycle(1'b1, mk(OP_LIMIT_SELL, 8'd2), 1'b0, '0, 1'b0, '0, 1'b0);
    tmp_c = mk(OP_LIMIT_BUY, 8'd3);
    do_cycle(1'b1, tmp_c, 1'b1, mk(OP_STOP_SELL, 8'd50), 1'b0, '0, 1'b0);
    check("full blocks", {last_ma, last_ia}, 2'b00);
    do_cycle(1'b1, tmp_c, 1'b0, '0, 1'b0, '0, 1'b1);
    check("pop+push accept", last_ia, 1'b1);
    idle(1'b1); idle(1'b1);

    // Cancel tail, cancel miss, cancel head racing a pop.
    do_cycle(1'b1, mk(OP_LIMIT_BUY, 8'd7), 1'b0, '0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, mk(OP_STOP_BUY, 8'd9), 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 8'd9, 1'b0);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 8'd4, 1'b0);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 8'd7, 1'b1);
    idle(1'b1);

    // Reset with two entries queued, then the starve counter starts from zero again.
    do_cycle(1'b1, rand_cmd(1'b0), 1'b0, '0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, rand_cmd(1'b1), 1'b0, '0, 1'b0);
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, rand_cmd(1'b0), 1'b1, rand_cmd(1'b1), 1'b0, '0, 1'b1);
      check("post-rst grant", {last_ma, last_ia}, exp_mtr_win[i] ? 2'b10 : 2'b01);
    end

    // Randomized traffic; sources hold a command until it is accepted.
    pi = 1'b0; pm = 1'b0; pic = '0; pmc = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) begin
        apply_reset();
        pi = 1'b0; pm = 1'b0;
      end
      if (!pi) begin pi = ($urandom_range(0, 99) < 55); pic = rand_cmd(1'b0); end
      if (!pm) begin pm = ($urandom_range(0, 99) < 55); pmc = rand_cmd(1'b1); end
      if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        tmp_c = exp_q[$urandom_range(0, exp_q.size() - 1)];
        cu = tmp_c.uid;
      end else begin
        cu = uid_t'($urandom_range(0, 255));
      end
      do_cycle(pi, pic, pm, pmc, $urandom_range(0, 99) < 20, cu, $urandom_range(0, 99) < 60);
      if (last_ia) pi = 1'b0;
      if (last_ma) pm = 1'b0;
    end
    idle(1'b1); idle(1'b1); idle(1'b1);

`ifdef OB_MTR_INJECT_STATS_EN
    check("stat_mtr_cnt_r", stat_mtr_cnt_r, stat_m_exp);
    check("stat_starve_cnt_r", stat_starve_cnt_r, 16'(stat_s_exp));
`endif
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
